// File: rtl/cpu_pkg.sv
// Shared constants, loader state encoding and control-word strobe positions
// for the 8-bit CPU datapath blocks.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_t;

  // Strobe positions within the control word issued by the control block
  localparam int CW_MAR_LOAD = 0;
  localparam int CW_RAM_WE   = 1;
  localparam int CW_RAM_OE   = 2;
  localparam int CW_W        = 3;

endpackage

// File: rtl/ram_mar_unit_if.sv
// Bus, CPU strobe and program-loader signals of the RAM/MAR responder.
// The master side (CPU/loader pins) drives strobes and data; the slave side answers.
interface ram_mar_unit_if;
  import cpu_pkg::*;

  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              load_mar;
  logic              ram_we;
  logic              ram_oe;
  logic              prog_en;
  logic [DATA_W-1:0] prog_data;
  logic              prog_valid;
  logic              prog_ready;
  logic              prog_done;
  logic [ADDR_W:0]   prog_ptr;
  logic              proto_err;

  modport master (
    output bus_in, load_mar, ram_we, ram_oe, prog_en, prog_data, prog_valid,
    input  bus_out, bus_oe, prog_ready, prog_done, prog_ptr, proto_err
  );

  modport slave (
    input  bus_in, load_mar, ram_we, ram_oe, prog_en, prog_data, prog_valid,
    output bus_out, bus_oe, prog_ready, prog_done, prog_ptr, proto_err
  );

endinterface

// File: rtl/ram_mar_unit_prog_loader.sv
// Program loader: fills RAM bytes 0..DEPTH-1 from a valid/ready stream, one byte per
// accepted cycle; ready only while loading, stalls on valid=0, stops in DONE.
module prog_loader
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_en,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [ADDR_W:0]   prog_ptr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  ld_state_t       state, state_nxt;
  logic [ADDR_W:0] ptr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LD_IDLE;
      prog_ptr <= '0;
    end else begin
      state    <= state_nxt;
      prog_ptr <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = prog_ptr;
    prog_ready = 1'b0;
    prog_done  = 1'b0;
    wr_en      = 1'b0;
    case (state)
      LD_IDLE: begin
        if (prog_en) begin
          state_nxt = LD_LOAD;
          ptr_nxt   = '0;
        end
      end
      LD_LOAD: begin
        // Dropping prog_en aborts before any further byte is taken
        prog_ready = prog_en;
        if (!prog_en) begin
          state_nxt = LD_IDLE;
        end else if (prog_valid) begin
          wr_en   = 1'b1;
          ptr_nxt = prog_ptr + PTR_ONE;
          if (prog_ptr == PTR_LAST) state_nxt = LD_DONE;
        end
      end
      LD_DONE: begin
        prog_done = 1'b1;
        if (!prog_en) state_nxt = LD_IDLE;
      end
      default: state_nxt = LD_IDLE;
    endcase
  end

  assign wr_addr = prog_ptr[ADDR_W-1:0];
  assign wr_data = prog_data;

endmodule

// File: rtl/ram_mar_unit.sv
// MAR + 16x8 RAM bus responder: zero-latency read onto the bus, writes and MAR
// loads at the clock edge; CPU strobes are masked while the program loader owns RAM.
module ram_mar_unit
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  ram_mar_unit_if.slave  bus
);

  logic [CW_W-1:0]   ctrl;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              proto_err_q;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  assign ctrl[CW_MAR_LOAD] = bus.load_mar & ~bus.prog_en;
  assign ctrl[CW_RAM_WE]   = bus.ram_we   & ~bus.prog_en;
  assign ctrl[CW_RAM_OE]   = bus.ram_oe   & ~bus.prog_en;

  prog_loader u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_en    (bus.prog_en),
    .prog_valid (bus.prog_valid),
    .prog_data  (bus.prog_data),
    .prog_ready (bus.prog_ready),
    .prog_done  (bus.prog_done),
    .prog_ptr   (bus.prog_ptr),
    .wr_en      (ld_we),
    .wr_addr    (ld_addr),
    .wr_data    (ld_data)
  );

  // Loader and CPU writes are mutually exclusive through prog_en; the write
  // address is the MAR value before any same-edge MAR load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar         <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (ld_we)
        mem[ld_addr] <= ld_data;
      else if (ctrl[CW_RAM_WE])
        mem[mar] <= bus.bus_in;
      if (ctrl[CW_MAR_LOAD])
        mar <= bus.bus_in[ADDR_W-1:0];
      if (ctrl[CW_RAM_WE] && ctrl[CW_RAM_OE])
        proto_err_q <= 1'b1;
    end
  end

  assign bus.bus_oe    = ctrl[CW_RAM_OE];
  assign bus.bus_out   = ctrl[CW_RAM_OE] ? mem[mar] : '0;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_ram_mar_unit.sv
// Scoreboard bench for ram_mar_unit: directed scenarios plus random traffic
// against a behavioural memory/loader model.
module tb_ram_mar_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_mar_unit_if bus_if ();

  ram_mar_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  typedef struct {
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       ready;
    logic       done;
    int         ptr;
    logic       err;
  } exp_t;

  exp_t sb [$];

  // Behavioural model: memory image, address register, loader progress
  logic [7:0] m_mem [16];
  logic [3:0] m_mar;
  int         m_ptr;
  int         m_mode;   // 0 idle, 1 loading, 2 complete
  logic       m_err;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_mar  = 4'h0;
    m_ptr  = 0;
    m_mode = 0;
    m_err  = 1'b0;
  endtask

  task automatic drive_idle();
    bus_if.bus_in     = 8'h00;
    bus_if.load_mar   = 1'b0;
    bus_if.ram_we     = 1'b0;
    bus_if.ram_oe     = 1'b0;
    bus_if.prog_en    = 1'b0;
    bus_if.prog_data  = 8'h00;
    bus_if.prog_valid = 1'b0;
  endtask

  // One bus cycle: drive, queue the expected outputs, then advance the model past the edge
  task automatic cyc(input bit ld, input bit we, input bit oe, input bit pe,
                     input bit [7:0] pd, input bit pv, input bit [7:0] bin);
    exp_t e;
    @(posedge clk);
    #1;
    bus_if.load_mar   = ld;
    bus_if.ram_we     = we;
    bus_if.ram_oe     = oe;
    bus_if.prog_en    = pe;
    bus_if.prog_data  = pd;
    bus_if.prog_valid = pv;
    bus_if.bus_in     = bin;
    e.bus_oe  = oe && !pe;
    e.bus_out = e.bus_oe ? m_mem[m_mar] : 8'h00;
    e.ready   = (m_mode == 1) && pe;
    e.done    = (m_mode == 2);
    e.ptr     = m_ptr;
    e.err     = m_err;
    sb.push_back(e);
    if (!pe) begin
      if (we) m_mem[m_mar] = bin;
      if (we && oe) m_err = 1'b1;
      if (ld) m_mar = bin[3:0];
      m_mode = 0;
    end else begin
      case (m_mode)
        0: begin m_mode = 1; m_ptr = 0; end
        1: if (pv) begin
             m_mem[m_ptr] = pd;
             m_ptr++;
             if (m_ptr == 16) m_mode = 2;
           end
        default: ;
      endcase
    end
  endtask

  task automatic read_addr(input int a);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, {4'($urandom), 4'(a)});
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bus_out"},    32'(bus_if.bus_out),    32'h0);
    chk({tag, "_bus_oe"},     32'(bus_if.bus_oe),     32'h0);
    chk({tag, "_prog_ready"}, 32'(bus_if.prog_ready), 32'h0);
    chk({tag, "_prog_done"},  32'(bus_if.prog_done),  32'h0);
    chk({tag, "_prog_ptr"},   32'(bus_if.prog_ptr),   32'h0);
    chk({tag, "_proto_err"},  32'(bus_if.proto_err),  32'h0);
  endtask

  task automatic reset_mid(input string tag);
    @(negedge clk);
    #2;
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs(tag);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare every queued expectation mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("bus_oe",     32'(bus_if.bus_oe),     32'(e.bus_oe));
        chk("bus_out",    32'(bus_if.bus_out),    32'(e.bus_out));
        chk("prog_ready", 32'(bus_if.prog_ready), 32'(e.ready));
        chk("prog_done",  32'(bus_if.prog_done),  32'(e.done));
        chk("prog_ptr",   32'(bus_if.prog_ptr),   32'(e.ptr));
        chk("proto_err",  32'(bus_if.proto_err),  32'(e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    bit pe;
    int nbytes;
    int c;
    drive_idle();
    model_reset();
    #12;
    check_reset_outputs("init_reset");
    #5;
    rst_n = 1'b1;

    // MAR=0 after reset reads a cleared word
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

    // Full program load with periodic stalls and masked CPU strobes
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
    nbytes = 0;
    c = 0;
    while (nbytes < 16) begin
      bit pv;
      pv = (c % 3) != 2;
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 8'h10 + 8'(nbytes), pv, 8'($urandom));
      if (pv) nbytes++;
      c++;
    end
    for (int i = 0; i < 3; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 8'($urandom), 1'b1, 8'($urandom));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    // CPU read of mem[5], upper bus bits ignored by MAR
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hC5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

    // Same-cycle MAR load and write: write lands at old MAR=3
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h03);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h0A);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    read_addr(3);

    // Abort after 5 bytes keeps the partial image
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hA0 + 8'(i), 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int a = 0; a < 6; a++) read_addr(a);

    // Read and write together: old data on the bus, sticky error
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h77);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    // Randomised mix of CPU traffic and loader sessions
    pe = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) pe = ~pe;
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
          pe, 8'($urandom), 1'($urandom), 8'($urandom));
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int a = 0; a < 16; a++) read_addr(a);

    // Reset in the middle of a load clears everything
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom), 1'b1, 8'h00);
    reset_mid("mid_load_reset");
    for (int a = 0; a < 16; a++) read_addr(a);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
